// File: rtl/decode_pkg.sv
// Shared definitions for the instruction decode stage: opcode values,
// instruction field positions (bit 0 is the MSB), the decoded entry type
// and the skid buffer state encoding.
package decode_pkg;

  // Widest immediate the stage can produce; narrower builds mask the top bits
  localparam int IMM_MAX_W = 64;

  // Supported opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Field positions in an instruction indexed [0:31], bit 0 being the MSB
  localparam int OPC_FIRST = 0;
  localparam int OPC_LAST  = 5;
  localparam int RS_FIRST  = 6;
  localparam int RS_LAST   = 10;
  localparam int RT_FIRST  = 11;
  localparam int RT_LAST   = 15;
  localparam int RD_FIRST  = 16;
  localparam int RD_LAST   = 20;
  localparam int SH_FIRST  = 21;
  localparam int SH_LAST   = 25;
  localparam int FN_FIRST  = 26;
  localparam int FN_LAST   = 31;
  localparam int IMM_FIRST = 16;
  localparam int IMM_LAST  = 31;
  localparam int JA_FIRST  = 6;
  localparam int JA_LAST   = 31;

  // One decoded instruction, as held in either buffer entry
  typedef struct packed {
    logic [4:0]           rs;
    logic [4:0]           rt;
    logic [4:0]           rd;
    logic [4:0]           shamt;
    logic [5:0]           funct;
    logic [IMM_MAX_W-1:0] imm;
    logic [25:0]          jaddr;
    logic                 rtype;
    logic                 itype;
    logic                 jtype;
    logic                 reg_write;
    logic                 mem_read;
    logic                 mem_write;
    logic                 branch;
    logic                 alu_src;
    logic                 illegal;
  } decoded_t;

  // Occupancy of the output register plus skid entry
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  // Sign-extend a 16-bit immediate to the widest immediate width
  function automatic logic [IMM_MAX_W-1:0] sext16(input logic [15:0] v);
    return {{(IMM_MAX_W-16){v[15]}}, v};
  endfunction

endpackage

// File: rtl/instr_decode_stage_decoder.sv
// Purely combinational MIPS field decoder: instruction -> decoded_t.
// Immediates are formed at full width and then masked to XLEN so that
// narrower builds keep the unused upper bits at zero.
module instr_field_decoder
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [0:31] instr,
  output decoded_t    dec
);

  localparam logic [IMM_MAX_W-1:0] IMM_MASK =
    (XLEN == 64) ? {IMM_MAX_W{1'b1}} : {32'h0000_0000, 32'hFFFF_FFFF};

  logic [5:0]           opcode_s;
  logic [15:0]          imm16_s;
  logic [IMM_MAX_W-1:0] imm_ext_s;

  assign opcode_s = instr[OPC_FIRST:OPC_LAST];
  assign imm16_s  = instr[IMM_FIRST:IMM_LAST];

  // Immediate extension: logical ops zero-extend, LUI shifts up, rest sign-extend
  always_comb begin
    imm_ext_s = sext16(imm16_s);
    case (opcode_s)
      OP_ANDI, OP_ORI, OP_XORI: imm_ext_s = {{(IMM_MAX_W-16){1'b0}}, imm16_s};
      OP_LUI:                   imm_ext_s = {{(IMM_MAX_W-32){imm16_s[15]}}, imm16_s, 16'h0000};
      default:                  imm_ext_s = sext16(imm16_s);
    endcase
  end

  // Field extraction, classification and main control signals
  always_comb begin
    dec       = '0;
    dec.rs    = instr[RS_FIRST:RS_LAST];
    dec.rt    = instr[RT_FIRST:RT_LAST];
    dec.rd    = instr[RD_FIRST:RD_LAST];
    dec.shamt = instr[SH_FIRST:SH_LAST];
    dec.funct = instr[FN_FIRST:FN_LAST];
    dec.jaddr = instr[JA_FIRST:JA_LAST];
    dec.imm   = imm_ext_s & IMM_MASK;
    case (opcode_s)
      OP_RTYPE: begin
        dec.rtype     = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_J: begin
        dec.jtype = 1'b1;
      end
      OP_JAL: begin
        dec.jtype     = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        dec.itype  = 1'b1;
        dec.branch = 1'b1;
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        dec.itype     = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      OP_LW: begin
        dec.itype     = 1'b1;
        dec.reg_write = 1'b1;
        dec.mem_read  = 1'b1;
        dec.alu_src   = 1'b1;
      end
      OP_SW: begin
        dec.itype     = 1'b1;
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered decode stage with a 2-entry skid buffer (output register plus
// one skid entry). in_ready is a flop that mirrors "skid entry empty", so
// out_ready never reaches in_ready combinationally.
// Optional feature: define DECODE_STATS_EN to add the stat_decoded and
// stat_illegal transfer counters.
module instr_decode_stage
  import decode_pkg::*;
#(
  parameter int               XLEN         = 32,
  parameter int               TAG_W        = 32,
  parameter logic [TAG_W-1:0] RESET_PC_TAG = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:31]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic [4:0]       out_rs,
  output logic [4:0]       out_rt,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_shamt,
  output logic [5:0]       out_funct,
  output logic [XLEN-1:0]  out_imm,
  output logic [25:0]      out_jaddr,
  output logic             out_rtype,
  output logic             out_itype,
  output logic             out_jtype,
  output logic             out_reg_write,
  output logic             out_mem_read,
  output logic             out_mem_write,
  output logic             out_branch,
  output logic             out_alu_src,
  output logic             out_illegal
`ifdef DECODE_STATS_EN
  ,
  output logic [31:0]      stat_decoded,
  output logic [31:0]      stat_illegal
`endif
);

  decoded_t         dec_s;
  decoded_t         out_r;
  decoded_t         skid_r;
  logic [TAG_W-1:0] out_tag_r;
  logic [TAG_W-1:0] skid_tag_r;
  logic             out_valid_r;
  logic             in_ready_r;
  skid_state_e      state_r;
  logic             accept_s;
  logic             pop_s;

  instr_field_decoder #(.XLEN(XLEN)) u_dec (
    .instr (in_instr),
    .dec   (dec_s)
  );

  assign accept_s = in_valid & in_ready_r;
  assign pop_s    = out_valid_r & out_ready;

  // Skid buffer FSM: flush beats every transfer; outputs are cleared when empty
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_EMPTY;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      out_r       <= '0;
      out_tag_r   <= RESET_PC_TAG;
      skid_r      <= '0;
      skid_tag_r  <= '0;
    end else if (flush) begin
      state_r     <= ST_EMPTY;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      out_r       <= '0;
      out_tag_r   <= RESET_PC_TAG;
      skid_r      <= '0;
      skid_tag_r  <= '0;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            out_r       <= dec_s;
            out_tag_r   <= in_tag;
            out_valid_r <= 1'b1;
            state_r     <= ST_ONE;
          end else begin
            state_r <= ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && pop_s) begin
            out_r     <= dec_s;
            out_tag_r <= in_tag;
          end else if (accept_s) begin
            skid_r     <= dec_s;
            skid_tag_r <= in_tag;
            in_ready_r <= 1'b0;
            state_r    <= ST_FULL;
          end else if (pop_s) begin
            out_r       <= '0;
            out_tag_r   <= RESET_PC_TAG;
            out_valid_r <= 1'b0;
            state_r     <= ST_EMPTY;
          end else begin
            state_r <= ST_ONE;
          end
        end
        ST_FULL: begin
          if (pop_s) begin
            out_r      <= skid_r;
            out_tag_r  <= skid_tag_r;
            in_ready_r <= 1'b1;
            state_r    <= ST_ONE;
          end else begin
            state_r <= ST_FULL;
          end
        end
        default: begin
          state_r     <= ST_EMPTY;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          out_r       <= '0;
          out_tag_r   <= RESET_PC_TAG;
        end
      endcase
    end
  end

`ifdef DECODE_STATS_EN
  logic [31:0] stat_decoded_r;
  logic [31:0] stat_illegal_r;

  // Transfer counters; they survive flush and wrap naturally
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_decoded_r <= 32'd0;
      stat_illegal_r <= 32'd0;
    end else if (pop_s && !flush) begin
      stat_decoded_r <= stat_decoded_r + 32'd1;
      if (out_r.illegal) begin
        stat_illegal_r <= stat_illegal_r + 32'd1;
      end else begin
        stat_illegal_r <= stat_illegal_r;
      end
    end else begin
      stat_decoded_r <= stat_decoded_r;
      stat_illegal_r <= stat_illegal_r;
    end
  end

  assign stat_decoded = stat_decoded_r;
  assign stat_illegal = stat_illegal_r;
`endif

  assign in_ready      = in_ready_r;
  assign out_valid     = out_valid_r;
  assign out_tag       = out_tag_r;
  assign out_rs        = out_r.rs;
  assign out_rt        = out_r.rt;
  assign out_rd        = out_r.rd;
  assign out_shamt     = out_r.shamt;
  assign out_funct     = out_r.funct;
  assign out_imm       = out_r.imm[XLEN-1:0];
  assign out_jaddr     = out_r.jaddr;
  assign out_rtype     = out_r.rtype;
  assign out_itype     = out_r.itype;
  assign out_jtype     = out_r.jtype;
  assign out_reg_write = out_r.reg_write;
  assign out_mem_read  = out_r.mem_read;
  assign out_mem_write = out_r.mem_write;
  assign out_branch    = out_r.branch;
  assign out_alu_src   = out_r.alu_src;
  assign out_illegal   = out_r.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Scoreboard bench for instr_decode_stage: a 32-bit and a 64-bit instance
// share stimulus; accepted instructions are modelled from the MIPS field
// rules and queued, and a monitor compares whatever each DUT presents.
module tb_instr_decode_stage;

  typedef struct packed {
    logic [31:0] tag;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [63:0] imm;
    logic [25:0] jaddr;
    logic        rtype;
    logic        itype;
    logic        jtype;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        br;
    logic        as;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_w = 32'h0;
  logic [31:0] in_tag = 32'h0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  int          ready_mode = 0;

  logic        in_ready, out_valid, in_ready64, out_valid64;
  logic [31:0] o_tag, o_tag64;
  logic [4:0]  o_rs, o_rt, o_rd, o_sh, o_rs64, o_rt64, o_rd64, o_sh64;
  logic [5:0]  o_fn, o_fn64;
  logic [31:0] o_imm;
  logic [63:0] o_imm64;
  logic [25:0] o_ja, o_ja64;
  logic [8:0]  o_ctl, o_ctl64;
`ifdef DECODE_STATS_EN
  logic [31:0] st_dec, st_ill, st_dec64, st_ill64;
`endif

  instr_decode_stage #(.XLEN(32)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_w), .in_tag(in_tag), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_tag(o_tag), .out_rs(o_rs), .out_rt(o_rt),
    .out_rd(o_rd), .out_shamt(o_sh), .out_funct(o_fn), .out_imm(o_imm),
    .out_jaddr(o_ja), .out_rtype(o_ctl[8]), .out_itype(o_ctl[7]),
    .out_jtype(o_ctl[6]), .out_reg_write(o_ctl[5]), .out_mem_read(o_ctl[4]),
    .out_mem_write(o_ctl[3]), .out_branch(o_ctl[2]), .out_alu_src(o_ctl[1]),
    .out_illegal(o_ctl[0])
`ifdef DECODE_STATS_EN
    , .stat_decoded(st_dec), .stat_illegal(st_ill)
`endif
  );

  instr_decode_stage #(.XLEN(64)) dut64 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_w), .in_tag(in_tag), .flush(flush), .out_valid(out_valid64),
    .out_ready(out_ready), .out_tag(o_tag64), .out_rs(o_rs64), .out_rt(o_rt64),
    .out_rd(o_rd64), .out_shamt(o_sh64), .out_funct(o_fn64), .out_imm(o_imm64),
    .out_jaddr(o_ja64), .out_rtype(o_ctl64[8]), .out_itype(o_ctl64[7]),
    .out_jtype(o_ctl64[6]), .out_reg_write(o_ctl64[5]), .out_mem_read(o_ctl64[4]),
    .out_mem_write(o_ctl64[3]), .out_branch(o_ctl64[2]), .out_alu_src(o_ctl64[1]),
    .out_illegal(o_ctl64[0])
`ifdef DECODE_STATS_EN
    , .stat_decoded(st_dec64), .stat_illegal(st_ill64)
`endif
  );

  exp_t act32, act64;
  assign act32 = {o_tag, o_rs, o_rt, o_rd, o_sh, o_fn, {32'h0, o_imm}, o_ja, o_ctl};
  assign act64 = {o_tag64, o_rs64, o_rt64, o_rd64, o_sh64, o_fn64, o_imm64, o_ja64, o_ctl64};

  // Reference model: MIPS decode rules on a normally indexed word
  function automatic exp_t model(input logic [31:0] w, input logic [31:0] tag);
    exp_t e;
    logic [5:0] op;
    logic [15:0] i16;
    logic legal;
    op  = w[31:26];
    i16 = w[15:0];
    e.tag = tag; e.rs = w[25:21]; e.rt = w[20:16]; e.rd = w[15:11];
    e.shamt = w[10:6]; e.funct = w[5:0]; e.jaddr = w[25:0];
    legal = op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0A,
                       6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
    if (op inside {6'h0C, 6'h0D, 6'h0E}) e.imm = {48'h0, i16};
    else if (op == 6'h0F) e.imm = {{32{i16[15]}}, i16, 16'h0};
    else e.imm = {{48{i16[15]}}, i16};
    e.rtype = (op == 6'h00);
    e.jtype = (op == 6'h02) || (op == 6'h03);
    e.itype = legal && !e.rtype && !e.jtype;
    e.rw = op inside {6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h03};
    e.mr = (op == 6'h23);
    e.mw = (op == 6'h2B);
    e.br = (op == 6'h04) || (op == 6'h05);
    e.as = e.itype && !e.br;
    e.ill = !legal;
    return e;
  endfunction

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_dec = 32'd0;
  logic [31:0] m_ill = 32'd0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever #5 clk = ~clk;

  // out_ready driver: forced low, forced high or random
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0: out_ready = 1'b0;
      1: out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: compares presented outputs on negedges, tracks async reset
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or negedge reset_n);
      if (!reset_n && clk) begin
        #1;
        exp_q.delete();
        m_dec = 32'd0; m_ill = 32'd0;
        chk("async_rst_valid", {159'd0, out_valid}, 160'd0);
        chk("async_rst_ready", {159'd0, in_ready}, 160'd1);
        chk("async_rst_outs", {3'd0, act32}, 160'd0);
      end else if (!reset_n) begin
        exp_q.delete();
        m_dec = 32'd0; m_ill = 32'd0;
        chk("rst_valid", {159'd0, out_valid}, 160'd0);
        chk("rst_ready", {159'd0, in_ready}, 160'd1);
        chk("rst_outs", {3'd0, act32}, 160'd0);
      end else begin
        chk("out_valid", {158'd0, out_valid64, out_valid}, {158'd0, {2{exp_q.size() != 0}}});
        chk("in_ready", {158'd0, in_ready64, in_ready}, {158'd0, {2{exp_q.size() < 2}}});
        if (exp_q.size() != 0) begin
          e = exp_q[0];
          chk("decode64", {3'd0, act64}, {3'd0, e});
          e.imm = {32'h0, e.imm[31:0]};
          chk("decode32", {3'd0, act32}, {3'd0, e});
        end else begin
          chk("empty_outs", {3'd0, act32}, 160'd0);
        end
`ifdef DECODE_STATS_EN
        chk("stat_decoded", {128'd0, st_dec}, {128'd0, m_dec});
        chk("stat_illegal", {128'd0, st_ill}, {128'd0, m_ill});
        chk("stat64", {96'd0, st_dec64, st_ill64}, {96'd0, m_dec, m_ill});
`endif
        if (flush) begin
          exp_q.delete();
        end else begin
          if (out_valid && out_ready && exp_q.size() != 0) begin
            m_dec = m_dec + 32'd1;
            if (exp_q[0].ill) m_ill = m_ill + 32'd1;
            void'(exp_q.pop_front());
          end
          if (in_valid && in_ready) exp_q.push_back(model(in_w, in_tag));
        end
      end
    end
  end

  logic [31:0] next_tag = 32'h0040_0000;

  // Present one instruction until it is accepted (bounded)
  task automatic send(input logic [31:0] w);
    bit acc;
    acc = 1'b0;
    in_w = w; in_tag = next_tag; in_valid = 1'b1;
    for (int k = 0; k < 300 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready && !flush;
      @(posedge clk); #2;
    end
    in_valid = 1'b0;
    next_tag = next_tag + 32'd4;
    if (!acc) begin
      $display("FAIL send_timeout: instr %h never accepted", w);
      $fatal(1, "send timeout");
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [0:12];
    logic [5:0] op;
    ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0A,
            6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
    if ($urandom_range(0, 4) == 0) op = 6'($urandom);
    else op = ops[$urandom_range(0, 12)];
    return {op, 26'($urandom)};
  endfunction

  logic [31:0] dir_list [0:13];

  initial begin
    dir_list = '{32'h012A4020, 32'h2008FFFF, 32'h3108FFFF, 32'hFC000000,
                 32'h3C018000, 32'hAC220004, 32'h8C22FFFC, 32'h08000123,
                 32'h0C000ABC, 32'h1022FFFE, 32'h14220001, 32'h2841FFFF,
                 32'h3421ABCD, 32'h3821F000};
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    ready_mode = 1;
    @(posedge clk); #2;

    // directed decode, full throughput
    for (int i = 0; i < 14; i++) send(dir_list[i]);
    repeat (3) @(posedge clk); #2;

    // back-pressure: three back-to-back with consumer stalled, then release
    ready_mode = 0;
    @(posedge clk); #2;
    fork
      begin
        send(32'h012A4020);
        send(32'h2008FFFF);
        send(32'hFC000000);
      end
      begin
        repeat (6) @(posedge clk);
        ready_mode = 1;
      end
    join
    repeat (4) @(posedge clk); #2;

    // flush while full with a same-cycle input that must be discarded
    ready_mode = 0;
    @(posedge clk); #2;
    send(32'h3108FFFF);
    send(32'h8C22FFFC);
    in_w = 32'hAC220004; in_tag = next_tag; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #2;
    flush = 1'b0; in_valid = 1'b0;
    ready_mode = 1;
    repeat (4) @(posedge clk); #2;

    // asynchronous reset mid-stream, away from the clock edge
    ready_mode = 0;
    @(posedge clk); #2;
    send(32'h0C000ABC);
    send(32'hFC000000);
    @(posedge clk); #3;
    reset_n = 1'b0;
    repeat (2) @(posedge clk); #2;
    reset_n = 1'b1;
    ready_mode = 1;
    send(32'h012A4020);
    repeat (2) @(posedge clk); #2;

    // random traffic with random back-pressure and occasional flushes
    ready_mode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #2;
      end
      if ($urandom_range(0, 39) == 0) begin
        flush = 1'b1;
        @(posedge clk); #2;
        flush = 1'b0;
      end
      send(rand_instr());
    end

    ready_mode = 1;
    repeat (10) @(posedge clk);
    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
